alu_mp_sequencer: RTL and testbench

Multi-precision arithmetic controller that drives the 16-bit ALU from the operand side.
- Splits a WORDS×16-bit add or subtract into 16-bit slices and issues them LSW first.
- Chains carry/borrow through the ALU's Cin and S modes, and assembles the wide result and wide C/V/Z/N flags.
- Sits between the CPU datapath's long-arithmetic path and the single-cycle ALU; the ALU is instantiated outside this block.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_mp_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_mp_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU mode encodings and multi-precision sequencer state type.
package alu_pkg;

    localparam logic [1:0] ALU_S_ADD = 2'b00;
    localparam logic [1:0] ALU_S_ADC = 2'b01;
    localparam logic [1:0] ALU_S_SUB = 2'b10;
    localparam logic [1:0] ALU_S_SBC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_mp_sequencer.sv
// Multi-precision add/subtract sequencer: feeds a 16-bit ALU slice by slice, LSW first.
// Optional ALU_MP_ABORT_EN adds an abort input and stages result writes until completion.
//
// state | meaning
// IDLE  | waiting for start; result and flags hold last values
// RUN   | one ALU slice per cycle, carry chained through alu_cin
// DONE  | one-cycle done pulse, result and flags valid
module alu_mp_sequencer
    import alu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic [16*WORDS-1:0] opa,
    input  logic [16*WORDS-1:0] opb,
    output logic [15:0]         alu_a,
    output logic [15:0]         alu_b,
    output logic                alu_cin,
    output logic [1:0]          alu_s,
    input  logic [15:0]         alu_result,
    input  logic                alu_c,
    input  logic                alu_v,
    input  logic                alu_z,
    input  logic                alu_n,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] result,
    output logic                c,
    output logic                v,
    output logic                z,
    output logic                n
`ifdef ALU_MP_ABORT_EN
    ,
    input  logic                abort
`endif
);

    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    seq_state_t    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic          z_acc;
    logic          op_lat;
    logic [W-1:0]  a_lat;
    logic [W-1:0]  b_lat;
    logic          last;

    assign last = (idx == IW'(WORDS - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_s   = ALU_S_ADD;
        alu_cin = 1'b0;
        if (state == RUN) begin
            alu_a = a_lat[{idx, 4'b0000} +: 16];
            alu_b = b_lat[{idx, 4'b0000} +: 16];
            if (idx == '0) begin
                alu_s = op_lat ? ALU_S_SUB : ALU_S_ADD;
            end else begin
                alu_s   = op_lat ? ALU_S_SBC : ALU_S_ADC;
                alu_cin = carry;
            end
        end
    end

`ifdef ALU_MP_ABORT_EN
    // Slices accumulate here so an aborted operation leaves result untouched.
    logic [W-1:0] stage;
    logic [W-1:0] stage_next;

    always_comb begin
        stage_next = stage;
        stage_next[{idx, 4'b0000} +: 16] = alu_result;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            z_acc  <= 1'b0;
            op_lat <= 1'b0;
            a_lat  <= '0;
            b_lat  <= '0;
            result <= '0;
            c      <= 1'b0;
            v      <= 1'b0;
            z      <= 1'b0;
            n      <= 1'b0;
`ifdef ALU_MP_ABORT_EN
            stage  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat  <= opa;
                        b_lat  <= opb;
                        op_lat <= op;
                        idx    <= '0;
                        carry  <= 1'b0;
                        z_acc  <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
`ifdef ALU_MP_ABORT_EN
                    if (abort) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        stage <= stage_next;
                        if (last) result <= stage_next;
`else
                    begin
                        result[{idx, 4'b0000} +: 16] <= alu_result;
`endif
                        carry <= alu_c;
                        z_acc <= z_acc & alu_z;
                        idx   <= idx + 1'b1;
                        if (last) begin
                            c     <= alu_c;
                            v     <= alu_v;
                            n     <= alu_n;
                            z     <= z_acc & alu_z;
                            idx   <= '0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Bench for alu_mp_sequencer (WORDS=2) with a behavioural 16-bit ALU attached.
module tb_alu_mp_sequencer;

    localparam int WORDS = 2;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] opa, opb;
    logic [15:0]  alu_a, alu_b, alu_result;
    logic         alu_cin, alu_c, alu_v, alu_z, alu_n;
    logic [1:0]   alu_s;
    logic         busy, done, c, v, z, n;
    logic [W-1:0] result;
`ifdef ALU_MP_ABORT_EN
    logic         abort;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s(alu_s),
        .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
        .busy(busy), .done(done), .result(result), .c(c), .v(v), .z(z), .n(n)
`ifdef ALU_MP_ABORT_EN
        , .abort(abort)
`endif
    );

    // Single-cycle 16-bit ALU: subtract modes compute A + ~B + carry-in.
    always_comb begin
        logic [16:0] s;
        case (alu_s)
            2'b00:   s = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   s = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
            2'b10:   s = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
            default: s = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'd0, alu_cin};
        endcase
        alu_result = s[15:0];
        alu_c      = s[16];
        alu_z      = (s[15:0] == 16'd0);
        alu_n      = s[15];
        if (alu_s[1]) alu_v = (alu_a[15] != alu_b[15]) && (s[15] != alu_a[15]);
        else          alu_v = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]);
    end

    // Wide reference: {result, c, v, z, n} from whole-number arithmetic.
    function automatic logic [W+3:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
        longint ua, ub, sa, sb, st;
        logic [W-1:0] r;
        logic cf, vf;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r  = W'(ua - ub);
            cf = (ua >= ub);
            st = sa - sb;
        end else begin
            r  = W'(ua + ub);
            cf = ((ua + ub) > 64'sh0000_0000_FFFF_FFFF);
            st = sa + sb;
        end
        vf = (st > 64'sh7FFF_FFFF) || (st < -64'sh8000_0000);
        return {r, cf, vf, (r == '0), r[W-1]};
    endfunction

    logic [1:0]   s_log   [8];
    logic         cin_log [8];
    logic         c_log   [8];
    int           done_cyc;
    logic [W-1:0] o_res;
    logic [3:0]   o_flags;
    logic         done_after, busy_after;

    // Issue one operation and record slice-level and completion observations.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge clk);
        opa = a; opb = b; op = sub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; opa = $urandom; opb = $urandom; op = ~sub;
        done_cyc = 0;
        for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                s_log[k-1] = alu_s; cin_log[k-1] = alu_cin; c_log[k-1] = alu_c;
            end
            if (done) begin
                done_cyc = k; o_res = result; o_flags = {c, v, z, n};
            end
        end
        @(negedge clk);
        done_after = done; busy_after = busy;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++; if ({c, v, z, n} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {c, v, z, n}); end
        n_cmp++; if ({alu_a, alu_b, alu_s, alu_cin} !== 35'd0) begin
            n_bad++; $display("FAIL reset_alu got a=%h b=%h s=%b cin=%b want all 0", alu_a, alu_b, alu_s, alu_cin);
        end
    endtask

    task automatic test_add_carry;
        logic [W+3:0] e;
        e = ref_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        n_cmp++; if (s_log[0] !== 2'b00) begin n_bad++; $display("FAIL add_s0 got %b want 00", s_log[0]); end
        n_cmp++; if (s_log[1] !== 2'b01) begin n_bad++; $display("FAIL add_s1 got %b want 01", s_log[1]); end
        n_cmp++; if (cin_log[1] !== 1'b1) begin n_bad++; $display("FAIL add_cin1 got %b want 1", cin_log[1]); end
        n_cmp++; if (done_cyc != 3) begin n_bad++; $display("FAIL add_latency got %0d want 3", done_cyc); end
        n_cmp++; if (o_res !== e[W+3:4] || o_res !== 32'h0001_0000) begin
            n_bad++; $display("FAIL add_result got %h want %h", o_res, e[W+3:4]);
        end
        n_cmp++; if (o_flags !== e[3:0]) begin n_bad++; $display("FAIL add_flags got %b want %b", o_flags, e[3:0]); end
        n_cmp++; if (done_after !== 1'b0 || busy_after !== 1'b0) begin
            n_bad++; $display("FAIL add_done_pulse got done=%b busy=%b want 0 0", done_after, busy_after);
        end
    endtask

    task automatic test_sub_borrow;
        logic [W+3:0] e;
        e = ref_op(32'h0001_0000, 32'h0000_0001, 1'b1);
        do_op(32'h0001_0000, 32'h0000_0001, 1'b1);
        n_cmp++; if (s_log[0] !== 2'b10) begin n_bad++; $display("FAIL sub_s0 got %b want 10", s_log[0]); end
        n_cmp++; if (c_log[0] !== 1'b0) begin n_bad++; $display("FAIL sub_c0 got %b want 0", c_log[0]); end
        n_cmp++; if (s_log[1] !== 2'b11 || cin_log[1] !== 1'b0) begin
            n_bad++; $display("FAIL sub_slice1 got s=%b cin=%b want 11 0", s_log[1], cin_log[1]);
        end
        n_cmp++; if (o_res !== e[W+3:4]) begin n_bad++; $display("FAIL sub_result got %h want %h", o_res, e[W+3:4]); end
        n_cmp++; if (o_flags !== 4'b1000) begin n_bad++; $display("FAIL sub_flags got %b want 1000", o_flags); end
    endtask

    task automatic test_edges;
        do_op(32'h1234_5678, 32'h1234_5678, 1'b1);
        n_cmp++; if ({o_res, o_flags} !== {32'h0, 4'b1010}) begin
            n_bad++; $display("FAIL sub_zero got %h/%b want 00000000/1010", o_res, o_flags);
        end
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        n_cmp++; if ({o_res, o_flags} !== {32'h8000_0000, 4'b0101}) begin
            n_bad++; $display("FAIL add_ovf got %h/%b want 80000000/0101", o_res, o_flags);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic sub;
        logic [W+3:0] e;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            if (i % 8 == 0) b = a;
            e = ref_op(a, b, sub);
            do_op(a, b, sub);
            n_cmp++; if ({done_cyc == 3, o_res, o_flags} !== {1'b1, e}) begin
                n_bad++;
                $display("FAIL random_%0d a=%h b=%h sub=%b got %h/%b cyc=%0d want %h/%b",
                         i, a, b, sub, o_res, o_flags, done_cyc, e[W+3:4], e[3:0]);
            end
        end
    endtask

    task automatic test_ignored_start;
        int dones;
        logic [W+3:0] e;
        logic [W-1:0] r;
        e = ref_op(32'hA5A5_0F0F, 32'h1111_2222, 1'b0);
        @(negedge clk);
        opa = 32'hA5A5_0F0F; opb = 32'h1111_2222; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; opa = 32'h0000_0003; opb = 32'h0000_0005; op = 1'b1;
        dones = 0; r = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) begin dones++; r = result; end
            start = (k == 1 || k == 3);
        end
        start = 1'b0;
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL ignore_start_dones got %0d want 1", dones); end
        n_cmp++; if (r !== e[W+3:4]) begin n_bad++; $display("FAIL ignore_start_result got %h want %h", r, e[W+3:4]); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_start_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [W+3:0] e;
        int found;
        e = ref_op(32'h0000_0010, 32'h0000_0020, 1'b1);
        @(negedge clk);
        opa = 32'h0000_0100; opb = 32'h0000_0200; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int k = 1; k <= 10 && found == 0; k++) begin
            @(negedge clk);
            if (done) found = k;
        end
        // Held through DONE (ignored) and the next IDLE edge (accepted).
        opa = 32'h0000_0010; opb = 32'h0000_0020; op = 1'b1; start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cyc = 0;
        for (int k = 1; k <= 10 && done_cyc == 0; k++) begin
            @(negedge clk);
            if (done) begin done_cyc = k; o_res = result; o_flags = {c, v, z, n}; end
        end
        n_cmp++; if (found != 3 || done_cyc != 3) begin
            n_bad++; $display("FAIL b2b_latency got %0d,%0d want 3,3", found, done_cyc);
        end
        n_cmp++; if ({o_res, o_flags} !== e) begin
            n_bad++; $display("FAIL b2b_result got %h/%b want %h/%b", o_res, o_flags, e[W+3:4], e[3:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dones;
        @(negedge clk);
        opa = 32'hDEAD_BEEF; opb = 32'h0123_4567; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy, done, c, v, z, n} !== 6'b0 || result !== '0) begin
            n_bad++; $display("FAIL midrst_state got busy=%b done=%b res=%h flags=%b want all 0",
                              busy, done, result, {c, v, z, n});
        end
        n_cmp++; if ({alu_a, alu_b, alu_s, alu_cin} !== 35'd0) begin
            n_bad++; $display("FAIL midrst_alu got a=%h b=%h s=%b cin=%b want all 0", alu_a, alu_b, alu_s, alu_cin);
        end
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL midrst_done got %0d want 0", dones); end
    endtask

`ifdef ALU_MP_ABORT_EN
    task automatic test_abort;
        logic [W+3:0] e;
        int dones;
        e = ref_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        opa = 32'h1234_5678; opb = 32'h0000_0001; op = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_cmp++; if (dones != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_done got dones=%0d busy=%b want 0 0", dones, busy);
        end
        n_cmp++; if ({result, c, v, z, n} !== e) begin
            n_bad++; $display("FAIL abort_hold got %h/%b want %h/%b", result, {c, v, z, n}, e[W+3:4], e[3:0]);
        end
    endtask
`endif

    initial begin
`ifdef ALU_MP_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_add_carry();
        test_sub_borrow();
        test_edges();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
`ifdef ALU_MP_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
